// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: destination select
// codes, the link register index and the arbiter state encoding.
package rf_wb_arbiter_pkg;

  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_LINK = 2'b10;
  localparam logic [1:0] DST_NONE = 2'b11;

  localparam int LINK_REG = 31;

  // Any state other than IDLE means the mul/div buffer holds a result.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PEND  = 2'b01,
    FORCE = 2'b10
  } arbState_t;

endpackage

// File: rtl/rf_wb_arbiter_wb_dest_sel.sv
// Resolves the pipeline writeback destination (rt / rd / link) and whether the
// resulting write may actually be performed ($0 and "no write" are suppressed).
module wb_dest_sel
  import rf_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [1:0]        dstSel,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  output logic [ADDR_W-1:0] addr,
  output logic              weOk
);

  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  always_comb begin
    addr = rt;
    weOk = 1'b1;
    case (dstSel)
      DST_RT:   addr = rt;
      DST_RD:   addr = rd;
      DST_LINK: addr = LINK_ADDR;
      DST_NONE: begin
        addr = rt;
        weOk = 1'b0;
      end
      default:  addr = rt;
    endcase
    if (addr == '0) weOk = 1'b0;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Single owner of the register-file write port: arbitrates pipeline writeback
// against a buffered mul/div result, forcing the buffer through after a bounded wait.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [1:0]        wb_dst_sel,
  input  logic [ADDR_W-1:0] wb_rt,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_stall,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] md_addr,
  input  logic [DATA_W-1:0] md_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [1:0]        dbgState
);

  // Handshake: a mul/div result transfers on a rising edge where md_valid and
  // md_ready are both high; the producer holds md_addr/md_data until then.
  // wb_stall high means the pipeline must re-present the same writeback next cycle.

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arbState_t         state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [ADDR_W-1:0] bufAddr;
  logic [DATA_W-1:0] bufData;
  logic              mdXfer;
  logic              grantWb;
  logic              grantBuf;
  logic [ADDR_W-1:0] wbAddr;
  logic              wbWeOk;

  wb_dest_sel #(.ADDR_W(ADDR_W)) u_dest_sel (
    .dstSel (wb_dst_sel),
    .rt     (wb_rt),
    .rd     (wb_rd),
    .addr   (wbAddr),
    .weOk   (wbWeOk)
  );

  assign md_ready = ~rst & (state == IDLE);
  assign mdXfer   = md_valid & md_ready;
  assign dbgState = state;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    grantWb   = 1'b0;
    grantBuf  = 1'b0;
    wb_stall  = 1'b0;
    case (state)
      IDLE: begin
        grantWb = wb_valid;
        if (mdXfer) begin
          stateNext = PEND;
          cntNext   = '0;
        end
      end
      PEND: begin
        if (!wb_valid) begin
          grantBuf  = 1'b1;
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          grantWb = 1'b1;
          if (cnt != CNT_MAX) cntNext = cnt + 1'b1;
          // This lost cycle is the one that reaches the limit.
          if (cnt >= CNT_MAX - 1'b1) stateNext = FORCE;
        end
      end
      FORCE: begin
        grantBuf  = 1'b1;
        wb_stall  = wb_valid;
        stateNext = IDLE;
        cntNext   = '0;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
    if (rst) wb_stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bufAddr  <= '0;
      bufData  <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (mdXfer) begin
        bufAddr <= md_addr;
        bufData <= md_data;
      end
      // A grant to $0 is still consumed; only the enable is suppressed.
      if (grantBuf) begin
        rf_we    <= (bufAddr != '0);
        rf_waddr <= bufAddr;
        rf_wdata <= bufData;
      end else if (grantWb) begin
        rf_we    <= wbWeOk;
        rf_waddr <= wbAddr;
        rf_wdata <= wb_data;
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

endmodule
